fir_tap_feeder: RTL and testbench



---
 rtl/fir_tap_feeder.sv | 118 +++++++++++
 tb/tb_fir_tap_feeder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_feeder.sv
// FIR front end: serial coefficient load into a TAPS-entry bank, then a TAPS-deep
// sample delay line that strobes a full window to the MAC on every accepted sample.
module fir_tap_feeder #(
    parameter int DATA_WIDTH = 13,
    parameter int TAPS       = 8
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic                       LOAD_START,
    input  logic                       COEF_VLD,
    input  logic [DATA_WIDTH-1:0]      COEF_DIN,
    input  logic [DATA_WIDTH-1:0]      DIN,
    input  logic                       VIN,
    output logic                       RDY_IN,
    input  logic                       MAC_RDY,
    output logic [TAPS*DATA_WIDTH-1:0] TP_W,
    output logic [TAPS*DATA_WIDTH-1:0] H,
    output logic                       WVOUT,
    output logic                       LOADED,
    output logic [1:0]                 DBG_STATE
);

    localparam int CW = $clog2(TAPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         coef_cnt, fill_cnt;
    logic [DATA_WIDTH-1:0] tap_q  [TAPS];
    logic [DATA_WIDTH-1:0] coef_q [TAPS];
    logic                  accept;
    logic                  wvout_q;

    // Handshake: a sample transfers on a rising edge where VIN && RDY_IN; the
    // upstream holds DIN stable until then. A LOAD_START in RUN discards a
    // sample presented in that same cycle even though RDY_IN is high.
    always_comb begin
        state_d = state_q;
        RDY_IN  = (state_q == S_RUN) && MAC_RDY;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: if (LOAD_START) state_d = S_LOAD;
            S_LOAD: begin
                if (!LOAD_START && COEF_VLD && coef_cnt == CW'(TAPS - 1))
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (LOAD_START) state_d = S_LOAD;
                else            accept  = VIN && MAC_RDY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            coef_cnt <= '0;
            fill_cnt <= '0;
            wvout_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                tap_q[i]  <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            wvout_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (LOAD_START) coef_cnt <= '0;
                S_LOAD: begin
                    if (LOAD_START) begin
                        // Restart takes priority; a coincident strobe lands in lane 0.
                        coef_cnt <= COEF_VLD ? CW'(1) : '0;
                        if (COEF_VLD) coef_q[0] <= COEF_DIN;
                    end else if (COEF_VLD) begin
                        for (int i = 0; i < TAPS; i++)
                            if (coef_cnt == CW'(i)) coef_q[i] <= COEF_DIN;
                        coef_cnt <= coef_cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (LOAD_START) begin
                        coef_cnt <= '0;
                        fill_cnt <= '0;
                        for (int i = 0; i < TAPS; i++) tap_q[i] <= '0;
                    end else if (accept) begin
                        for (int i = TAPS - 1; i > 0; i--) tap_q[i] <= tap_q[i-1];
                        tap_q[0] <= DIN;
                        if (fill_cnt != CW'(TAPS)) fill_cnt <= fill_cnt + CW'(1);
                        wvout_q <= (fill_cnt >= CW'(TAPS - 1));
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        TP_W = '0;
        H    = '0;
        for (int i = 0; i < TAPS; i++) begin
            TP_W[i*DATA_WIDTH +: DATA_WIDTH] = tap_q[i];
            H[i*DATA_WIDTH +: DATA_WIDTH]    = coef_q[i];
        end
    end

    assign WVOUT     = wvout_q;
    assign LOADED    = (state_q == S_RUN);
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Randomised and directed bench for fir_tap_feeder against a queue-based model.
module tb_fir_tap_feeder;

    localparam int DW   = 13;
    localparam int TAPS = 8;
    localparam int VW   = 2 * TAPS * DW + 2;

    logic                 CLK = 1'b0;
    logic                 RST_n = 1'b0;
    logic                 LOAD_START = 1'b0;
    logic                 COEF_VLD = 1'b0;
    logic [DW-1:0]        COEF_DIN = '0;
    logic [DW-1:0]        DIN = '0;
    logic                 VIN = 1'b0;
    logic                 RDY_IN;
    logic                 MAC_RDY = 1'b1;
    logic [TAPS*DW-1:0]   TP_W;
    logic [TAPS*DW-1:0]   H;
    logic                 WVOUT;
    logic                 LOADED;
    logic [1:0]           DBG_STATE;

    int checks = 0;
    int errors = 0;

    fir_tap_feeder #(.DATA_WIDTH(DW), .TAPS(TAPS)) dut (
        .CLK(CLK), .RST_n(RST_n), .LOAD_START(LOAD_START), .COEF_VLD(COEF_VLD),
        .COEF_DIN(COEF_DIN), .DIN(DIN), .VIN(VIN), .RDY_IN(RDY_IN), .MAC_RDY(MAC_RDY),
        .TP_W(TP_W), .H(H), .WVOUT(WVOUT), .LOADED(LOADED), .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 loading coefficients, 2 running
    int             m_mode;
    int             m_ncoef;
    int             m_accepts;
    logic           m_wv;
    logic [DW-1:0]  m_h [TAPS];
    logic [DW-1:0]  m_win [$];

    task automatic model_reset();
        m_mode = 0; m_ncoef = 0; m_accepts = 0; m_wv = 1'b0;
        m_win.delete();
        for (int i = 0; i < TAPS; i++) begin
            m_h[i] = '0;
            m_win.push_back('0);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        m_wv = 1'b0;
        if (m_mode == 0) begin
            if (LOAD_START) begin m_mode = 1; m_ncoef = 0; end
        end else if (m_mode == 1) begin
            if (LOAD_START) begin
                m_ncoef = 0;
                if (COEF_VLD) begin m_h[0] = COEF_DIN; m_ncoef = 1; end
            end else if (COEF_VLD) begin
                m_h[m_ncoef] = COEF_DIN;
                m_ncoef++;
                if (m_ncoef == TAPS) m_mode = 2;
            end
        end else begin
            if (LOAD_START) begin
                m_mode = 1; m_ncoef = 0; m_accepts = 0;
                for (int i = 0; i < TAPS; i++) m_win[i] = '0;
            end else if (VIN && MAC_RDY) begin
                m_win.push_front(DIN);
                void'(m_win.pop_back());
                m_accepts++;
                m_wv = (m_accepts >= TAPS);
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < TAPS; i++) begin
            v[TAPS*DW + i*DW +: DW] = m_win[i];
            v[i*DW +: DW]           = m_h[i];
        end
        v[VW-1] = m_wv;
        v[VW-2] = (m_mode == 2);
        return v;
    endfunction

    logic [VW-1:0] obs_vec;
    assign obs_vec = {WVOUT, LOADED, TP_W, H};

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        LOAD_START = 1'b0; COEF_VLD = 1'b0; VIN = 1'b0; MAC_RDY = 1'b1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        RST_n = 1'b0;
        model_reset();
        tick();
        RST_n = 1'b1;
    endtask

    task automatic load_coefs(input logic random_vals);
        idle_inputs();
        LOAD_START = 1'b1; model_step(); tick();
        LOAD_START = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            COEF_VLD = 1'b1;
            COEF_DIN = random_vals ? DW'($urandom) : DW'(k + 1);
            model_step(); tick();
        end
        COEF_VLD = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        MAC_RDY = 1'b1; #1;
        checks++;
        if (obs_vec !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", obs_vec);
        end
        checks++;
        if (RDY_IN !== 1'b0) begin
            errors++; $display("FAIL reset_rdy got=%b want=0", RDY_IN);
        end
    endtask

    task automatic test_load();
        logic [TAPS*DW-1:0] want_h;
        idle_inputs();
        LOAD_START = 1'b1; model_step(); tick();
        LOAD_START = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            COEF_VLD = 1'b1; COEF_DIN = DW'(k + 1);
            model_step(); tick();
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++; $display("FAIL load_step%0d got=%h want=%h", k, obs_vec, exp_vec());
            end
        end
        COEF_VLD = 1'b0;
        for (int k = 0; k < TAPS; k++) want_h[k*DW +: DW] = DW'(k + 1);
        checks++;
        if (H !== want_h || LOADED !== 1'b1) begin
            errors++; $display("FAIL load_final H=%h loaded=%b want H=%h loaded=1", H, LOADED, want_h);
        end
        MAC_RDY = 1'b1; #1;
        checks++;
        if (RDY_IN !== 1'b1) begin
            errors++; $display("FAIL load_rdy got=%b want=1", RDY_IN);
        end
    endtask

    task automatic test_priming();
        for (int k = 1; k <= TAPS; k++) begin
            VIN = 1'b1; MAC_RDY = 1'b1; DIN = DW'(k * 10);
            model_step(); tick();
            checks++;
            if (obs_vec !== exp_vec() || WVOUT !== (k == TAPS)) begin
                errors++; $display("FAIL prime_%0d got=%h want=%h", k, obs_vec, exp_vec());
            end
        end
        VIN = 1'b0;
        checks++;
        if (TP_W[0 +: DW] !== DW'(80) || TP_W[7*DW +: DW] !== DW'(10)) begin
            errors++; $display("FAIL prime_lanes lane0=%0d lane7=%0d want 80/10",
                               TP_W[0 +: DW], TP_W[7*DW +: DW]);
        end
    endtask

    task automatic test_streaming();
        VIN = 1'b1; DIN = DW'(90);
        model_step(); tick();
        checks++;
        if (WVOUT !== 1'b1 || TP_W[0 +: DW] !== DW'(90) || TP_W[7*DW +: DW] !== DW'(20)) begin
            errors++; $display("FAIL stream_90 wv=%b lane0=%0d lane7=%0d want 1/90/20",
                               WVOUT, TP_W[0 +: DW], TP_W[7*DW +: DW]);
        end
        DIN = 13'h1000;
        model_step(); tick();
        VIN = 1'b0;
        checks++;
        if (obs_vec !== exp_vec() || TP_W[0 +: DW] !== 13'h1000) begin
            errors++; $display("FAIL stream_neg got=%h want=%h", obs_vec, exp_vec());
        end
        model_step(); tick();
        checks++;
        if (WVOUT !== 1'b0) begin
            errors++; $display("FAIL stream_idle_wv got=%b want=0", WVOUT);
        end
    endtask

    task automatic test_backpressure();
        VIN = 1'b1; MAC_RDY = 1'b0; DIN = DW'($urandom);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (RDY_IN !== 1'b0) begin
                errors++; $display("FAIL bp_rdy%0d got=%b want=0", k, RDY_IN);
            end
            model_step(); tick();
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++; $display("FAIL bp_hold%0d got=%h want=%h", k, obs_vec, exp_vec());
            end
        end
        MAC_RDY = 1'b1;
        model_step(); tick();
        VIN = 1'b0;
        checks++;
        if (obs_vec !== exp_vec() || WVOUT !== 1'b1 || TP_W[0 +: DW] !== DIN) begin
            errors++; $display("FAIL bp_release got=%h want=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_reload();
        LOAD_START = 1'b1; VIN = 1'b1; MAC_RDY = 1'b1; DIN = DW'($urandom);
        model_step(); tick();
        LOAD_START = 1'b0;
        #1;
        checks++;
        if (TP_W !== '0 || LOADED !== 1'b0 || RDY_IN !== 1'b0 || WVOUT !== 1'b0) begin
            errors++; $display("FAIL reload_flush tp=%h loaded=%b rdy=%b want 0/0/0",
                               TP_W, LOADED, RDY_IN);
        end
        VIN = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            COEF_VLD = 1'b1; COEF_DIN = DW'($urandom);
            model_step(); tick();
        end
        COEF_VLD = 1'b0;
        for (int k = 1; k <= TAPS; k++) begin
            VIN = 1'b1; DIN = DW'($urandom);
            model_step(); tick();
            checks++;
            if (obs_vec !== exp_vec() || WVOUT !== (k == TAPS)) begin
                errors++; $display("FAIL reload_prime%0d got=%h want=%h", k, obs_vec, exp_vec());
            end
        end
        VIN = 1'b0;
    endtask

    task automatic test_reset_midload();
        idle_inputs();
        LOAD_START = 1'b1; model_step(); tick();
        LOAD_START = 1'b0;
        for (int k = 0; k < 4; k++) begin
            COEF_VLD = 1'b1; COEF_DIN = DW'($urandom_range(1, 4000));
            model_step(); tick();
        end
        COEF_VLD = 1'b0;
        apply_reset();
        checks++;
        if (H !== '0 || LOADED !== 1'b0) begin
            errors++; $display("FAIL midload_reset H=%h loaded=%b want 0/0", H, LOADED);
        end
        for (int k = 0; k < 4; k++) begin
            COEF_VLD = 1'b1; COEF_DIN = DW'($urandom_range(1, 4000));
            model_step(); tick();
        end
        COEF_VLD = 1'b0;
        checks++;
        if (H !== '0 || obs_vec !== exp_vec()) begin
            errors++; $display("FAIL idle_coef_ignored H=%h want 0", H);
        end
    endtask

    task automatic test_random();
        load_coefs(1'b1);
        for (int n = 0; n < 400; n++) begin
            LOAD_START = ($urandom_range(0, 39) == 0);
            COEF_VLD   = ($urandom_range(0, 1) == 1);
            COEF_DIN   = DW'($urandom);
            VIN        = ($urandom_range(0, 3) != 0);
            MAC_RDY    = ($urandom_range(0, 4) != 0);
            DIN        = DW'($urandom);
            #1;
            checks++;
            if (RDY_IN !== ((m_mode == 2) && MAC_RDY)) begin
                errors++; $display("FAIL rand_rdy%0d got=%b", n, RDY_IN);
            end
            if ($urandom_range(0, 149) == 0) begin
                apply_reset();
            end else begin
                model_step(); tick();
            end
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++; $display("FAIL rand_cycle%0d got=%h want=%h", n, obs_vec, exp_vec());
            end
        end
        idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_load();
        test_priming();
        test_streaming();
        test_backpressure();
        test_reload();
        test_reset_midload();
        apply_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
